// File: rtl/pu_program_loader_if.sv
// Program-image word stream into pu_program_loader (valid/ready handshake).
interface pu_program_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] pu_data_in;
  logic [ATTR_WIDTH-1:0] pu_attr_in;
  logic                  pu_valid_in;
  logic                  pu_ready_out;

  modport master (output pu_data_in, pu_attr_in, pu_valid_in, input pu_ready_out);
  modport slave  (input pu_data_in, pu_attr_in, pu_valid_in, output pu_ready_out);
endinterface

// File: rtl/pu_program_loader.sv
// Unpacks a streamed program image into PU program memory and optionally jumps to it.
// Optional trailer checksum check enabled by defining PU_LOADER_CHECKSUM_EN.
module pu_program_loader #(
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned ATTR_WIDTH           = 4,
  parameter int unsigned PROGRAM_SIZE         = 200,
  parameter int unsigned INSTRUCTION_SIZE     = 16,
  parameter int unsigned PROGRAM_COUNTER_SIZE = $clog2(PROGRAM_SIZE)
) (
  input  logic                            pu_clk,
  input  logic                            pu_rst,
  pu_program_loader_if.slave              stream,
  output logic                            mem_we,
  output logic [PROGRAM_COUNTER_SIZE-1:0] mem_addr,
  output logic [INSTRUCTION_SIZE-1:0]     mem_wdata,
  output logic                            pu_jump,
  output logic [DATA_WIDTH-1:0]           pu_jump_addr,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned FIELD_W = 16;
  localparam int unsigned END_W   = FIELD_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE_HI,
`ifdef PU_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } state_e;

`ifdef PU_LOADER_CHECKSUM_EN
  localparam state_e LAST_ST = ST_CHECK;
`else
  localparam state_e LAST_ST = ST_DONE;
`endif

  state_e                          state_q, state_d;
  logic [FIELD_W-1:0]              base_q, base_d;
  logic [FIELD_W-1:0]              remaining_q, remaining_d;
  logic [FIELD_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic                            autostart_q, autostart_d;
  logic [INSTRUCTION_SIZE-1:0]     hi_q, hi_d;
  logic                            ready_q, ready_d;
  logic                            mem_we_q, mem_we_d;
  logic [PROGRAM_COUNTER_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [INSTRUCTION_SIZE-1:0]     mem_wdata_q, mem_wdata_d;
  logic                            jump_q, jump_d;
  logic [DATA_WIDTH-1:0]           jump_addr_q, jump_addr_d;
  logic                            busy_q, busy_d;
  logic                            error_q, error_d;
`ifdef PU_LOADER_CHECKSUM_EN
  logic [INSTRUCTION_SIZE-1:0]     cs_q, cs_d;
  logic                            cs_bad_q, cs_bad_d;
`endif

  logic                        accept_c, is_hdr_c, hdr_fits_c;
  logic [FIELD_W-1:0]          hdr_base_c, hdr_len_c;
  logic [END_W-1:0]            hdr_end_c;
  logic [INSTRUCTION_SIZE-1:0] lo_c, hi_c;
  logic                        attr_unused_c;

  assign accept_c      = stream.pu_valid_in && ready_q;
  assign is_hdr_c      = stream.pu_attr_in[0];
  assign hdr_base_c    = stream.pu_data_in[FIELD_W-1:0];
  assign hdr_len_c     = stream.pu_data_in[2*FIELD_W-1:FIELD_W];
  assign hdr_end_c     = END_W'(hdr_base_c) + END_W'(hdr_len_c);
  assign hdr_fits_c    = (hdr_end_c <= END_W'(PROGRAM_SIZE));
  assign lo_c          = stream.pu_data_in[INSTRUCTION_SIZE-1:0];
  assign hi_c          = stream.pu_data_in[DATA_WIDTH-1:INSTRUCTION_SIZE];
  assign attr_unused_c = ^stream.pu_attr_in[ATTR_WIDTH-1:2];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    wr_ptr_d    = wr_ptr_q;
    autostart_d = autostart_q;
    hi_d        = hi_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    jump_d      = 1'b0;
    jump_addr_d = '0;
`ifdef PU_LOADER_CHECKSUM_EN
    cs_d        = cs_q;
    cs_bad_d    = cs_bad_q;
`endif

    case (state_q)
      ST_WRITE_HI: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = PROGRAM_COUNTER_SIZE'(wr_ptr_q);
        mem_wdata_d = hi_q;
        wr_ptr_d    = wr_ptr_q + FIELD_W'(1);
        remaining_d = remaining_q - FIELD_W'(1);
`ifdef PU_LOADER_CHECKSUM_EN
        cs_d        = cs_q ^ hi_q;
`endif
        state_d     = (remaining_q == FIELD_W'(1)) ? LAST_ST : ST_LOAD;
      end

      ST_DONE: begin
`ifdef PU_LOADER_CHECKSUM_EN
        jump_d = autostart_q && !cs_bad_q;
`else
        jump_d = autostart_q;
`endif
        jump_addr_d = jump_d ? DATA_WIDTH'(base_q) : '0;
        state_d     = ST_IDLE;
      end

      default: begin
        // A header seen mid-load aborts that load, then starts over as from IDLE.
        if (accept_c && is_hdr_c) begin
          if (state_q != ST_IDLE) error_d = 1'b1;
          if (hdr_fits_c) begin
            base_d      = hdr_base_c;
            wr_ptr_d    = hdr_base_c;
            remaining_d = hdr_len_c;
            autostart_d = stream.pu_attr_in[1];
`ifdef PU_LOADER_CHECKSUM_EN
            cs_d        = '0;
            cs_bad_d    = 1'b0;
`endif
            state_d     = (hdr_len_c == '0) ? LAST_ST : ST_LOAD;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (accept_c && (state_q == ST_LOAD)) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = PROGRAM_COUNTER_SIZE'(wr_ptr_q);
          mem_wdata_d = lo_c;
          wr_ptr_d    = wr_ptr_q + FIELD_W'(1);
          remaining_d = remaining_q - FIELD_W'(1);
`ifdef PU_LOADER_CHECKSUM_EN
          cs_d        = cs_q ^ lo_c;
`endif
          if (remaining_q == FIELD_W'(1)) begin
            state_d = LAST_ST;
          end else begin
            hi_d    = hi_c;
            state_d = ST_WRITE_HI;
          end
        end
`ifdef PU_LOADER_CHECKSUM_EN
        else if (accept_c && (state_q == ST_CHECK)) begin
          if (lo_c != cs_q) begin
            cs_bad_d = 1'b1;
            error_d  = 1'b1;
          end
          state_d = ST_DONE;
        end
`endif
      end
    endcase

`ifdef PU_LOADER_CHECKSUM_EN
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
`endif
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge pu_clk) begin
    if (pu_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      autostart_q <= 1'b0;
      hi_q        <= '0;
      ready_q     <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PU_LOADER_CHECKSUM_EN
      cs_q        <= '0;
      cs_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      autostart_q <= autostart_d;
      hi_q        <= hi_d;
      ready_q     <= ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      jump_q      <= jump_d;
      jump_addr_q <= jump_addr_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
`ifdef PU_LOADER_CHECKSUM_EN
      cs_q        <= cs_d;
      cs_bad_q    <= cs_bad_d;
`endif
    end
  end

  assign stream.pu_ready_out = ready_q;
  assign mem_we              = mem_we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = mem_wdata_q;
  assign pu_jump             = jump_q;
  assign pu_jump_addr        = jump_addr_q;
  assign busy                = busy_q;
  assign error               = error_q;

endmodule

// File: tb/tb_pu_program_loader.sv
// Directed bench for pu_program_loader: per-cycle vector table plus hand-written corner sequences.
module tb_pu_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        jump;
  logic [31:0] jump_addr;
  logic        busy;
  logic        error;

  pu_program_loader_if #(.DATA_WIDTH(32), .ATTR_WIDTH(4)) bus ();

  pu_program_loader dut (
    .pu_clk       (clk),
    .pu_rst       (rst),
    .stream       (bus.slave),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .pu_jump      (jump),
    .pu_jump_addr (jump_addr),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  attr;
    logic [31:0] data;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        jmp;
    logic [31:0] jaddr;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] a, input logic [31:0] d,
                              input logic rdy, input logic we, input logic [7:0] addr, input logic [15:0] wd,
                              input logic jmp, input logic [31:0] ja, input logic bsy, input logic err);
    vec_t x;
    x.rst = r;  x.vld = v;   x.attr = a;    x.data = d;
    x.rdy = rdy; x.we = we;  x.addr = addr; x.wd = wd;
    x.jmp = jmp; x.jaddr = ja; x.bsy = bsy; x.err = err;
    return x;
  endfunction

  // Addr/data only matter on a write, jump address only on a jump.
  function automatic logic [63:0] obs(input logic rdy, input logic we, input logic [7:0] addr,
                                      input logic [15:0] wd, input logic jmp, input logic [31:0] ja,
                                      input logic bsy, input logic err, input logic we_e, input logic jmp_e);
    return {3'b000, rdy, we, we_e ? addr : 8'h00, we_e ? wd : 16'h0000,
            jmp, jmp_e ? ja : 32'h0, bsy, err};
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [31:0] d);
    rst             = r;
    bus.pu_valid_in = v;
    bus.pu_attr_in  = a;
    bus.pu_data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        seen;
  int          jumps;
  logic [31:0] ja_seen;

  initial begin
    rst             = 1'b1;
    bus.pu_valid_in = 1'b0;
    bus.pu_attr_in  = '0;
    bus.pu_data_in  = '0;

`ifndef PU_LOADER_CHECKSUM_EN
    //            rst vld attr data          rdy we addr wd        jmp ja  bsy err
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h0003_000A,  1, 0, 0,   16'h0,    0, 0,  1, 0));
    tbl.push_back(mk(0, 1, 0, 32'hBBBB_AAAA,  0, 1, 10,  16'hAAAA, 0, 0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 1, 11,  16'hBBBB, 0, 0,  1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0000_CCCC,  0, 1, 12,  16'hCCCC, 0, 0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    1, 10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h1234_5678,  1, 0, 0,   16'h0,    0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0003_00C6,  1, 0, 0,   16'h0,    0, 0,  0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 1));
    tbl.push_back(mk(0, 1, 1, 32'h0002_00C6,  1, 0, 0,   16'h0,    0, 0,  1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h2222_1111,  0, 1, 198, 16'h1111, 0, 0,  1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0, 1, 199, 16'h2222, 0, 0,  1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0004_0000,  1, 0, 0,   16'h0,    0, 0,  1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h4444_3333,  0, 1, 0,   16'h3333, 0, 0,  1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 1, 1,   16'h4444, 0, 0,  1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0001_0032,  1, 0, 0,   16'h0,    0, 0,  1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h9999_5555,  0, 1, 50,  16'h5555, 0, 0,  1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 1));
    tbl.push_back(mk(0, 1, 3, 32'h0000_0007,  0, 0, 0,   16'h0,    0, 0,  1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    1, 7,  0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1, 0, 0,   16'h0,    0, 0,  0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].attr, tbl[i].data);
      chk($sformatf("row%0d", i),
          obs(bus.pu_ready_out, mem_we, mem_addr, mem_wdata, jump, jump_addr, busy, error,
              tbl[i].we, tbl[i].jmp),
          obs(tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].jmp, tbl[i].jaddr,
              tbl[i].bsy, tbl[i].err, tbl[i].we, tbl[i].jmp));
    end
`endif

    // Stalled payload, then reset while the high half is pending.
    step(1, 0, 0, 32'h0);
    step(0, 1, 4'h3, 32'h0004_0014);
    chk("rm_hdr_busy", 64'(busy), 64'(1'b1));
    step(0, 1, 4'h0, 32'h0B0B_0A0A);
    chk("rm_w0", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd20, 16'h0A0A}));
    step(0, 0, 4'h0, 32'h0);
    chk("rm_w1", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd21, 16'h0B0B}));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'h0, 32'h0);
      chk($sformatf("rm_stall%0d", i), 64'({mem_we, busy, bus.pu_ready_out}), 64'(3'b011));
    end
    step(0, 1, 4'h0, 32'h0D0D_0C0C);
    chk("rm_w2", 64'({mem_we, mem_addr, mem_wdata, bus.pu_ready_out}), 64'({1'b1, 8'd22, 16'h0C0C, 1'b0}));
    step(1, 0, 4'h0, 32'h0);
    chk("rm_rst", 64'({busy, error, mem_we, bus.pu_ready_out, jump}), 64'(5'b00010));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'h0, 32'h0);
      seen = seen | jump | mem_we | busy;
    end
    chk("rm_quiet", 64'(seen), 64'(1'b0));

`ifdef PU_LOADER_CHECKSUM_EN
    // Matching trailer: 0x00FF ^ 0x00F0 = 0x000F, then a mismatching one.
    for (int pass = 0; pass < 2; pass++) begin
      step(1, 0, 4'h0, 32'h0);
      step(0, 1, 4'h3, 32'h0002_0000);
      step(0, 1, 4'h0, 32'h00F0_00FF);
      chk($sformatf("cs%0d_w0", pass), 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd0, 16'h00FF}));
      step(0, 0, 4'h0, 32'h0);
      chk($sformatf("cs%0d_w1", pass), 64'({mem_we, mem_addr, mem_wdata, bus.pu_ready_out}),
          64'({1'b1, 8'd1, 16'h00F0, 1'b1}));
      step(0, 1, 4'h0, (pass == 0) ? 32'h0000_000F : 32'h0000_0001);
      jumps   = 0;
      ja_seen = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 4'h0, 32'h0);
        if (jump) begin
          jumps++;
          ja_seen = jump_addr;
        end
      end
      if (pass == 0) begin
        chk("cs_ok_jump", 64'(jumps), 64'(1));
        chk("cs_ok_addr", 64'(ja_seen), 64'(32'h0));
        chk("cs_ok_err", 64'(error), 64'(1'b0));
      end else begin
        chk("cs_bad_jump", 64'(jumps), 64'(0));
        chk("cs_bad_err", 64'(error), 64'(1'b1));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_program_loader.md
Name: pu_program_loader

Overview:
- Writer-side counterpart of the PU control sequencer. The sequencer reads instruction words from program memory and jumps on pu_jump.
- This block receives a program image over a valid/ready word stream, unpacks instructions and writes them into the program memory write port.
- After a complete load it optionally issues a one-cycle jump to the sequencer with the program's start address.

Parameters:
- DATA_WIDTH, 32, stream word width; must be 2*INSTRUCTION_SIZE.
- ATTR_WIDTH, 4, stream attribute width.
- PROGRAM_SIZE, 200, program memory depth in instructions.
- INSTRUCTION_SIZE, 16, instruction width.
- PROGRAM_COUNTER_SIZE, $clog2(PROGRAM_SIZE), memory address width.

Ports:
- pu_clk  in  1  clock; all logic on rising edge.
- pu_rst  in  1  reset, synchronous, active-high.
- pu_data_in  in  DATA_WIDTH  stream word.
- pu_attr_in  in  ATTR_WIDTH  attr[0]=header marker, attr[1]=autostart (header only); attr[3:2] ignored.
- pu_valid_in  in  1  stream word valid.
- pu_ready_out  out  1  block accepts word this cycle.
- mem_we  out  1  program memory write enable.
- mem_addr  out  PROGRAM_COUNTER_SIZE  write address.
- mem_wdata  out  INSTRUCTION_SIZE  write data.
- pu_jump  out  1  one-cycle jump strobe to sequencer.
- pu_jump_addr  out  DATA_WIDTH  jump target, zero-extended start address.
- busy  out  1  high when not IDLE.
- error  out  1  sticky error flag.

Behaviour:
- Transfer occurs when pu_valid_in && pu_ready_out at a clock edge.
- Reset values: all outputs 0 except pu_ready_out=1. State returns to IDLE and error clears. Reset mid-load abandons the load with no jump; words already written stay in memory.
- Header word: base = data[15:0], len = data[31:16] in instructions. attr[1] is latched as autostart.
- State IDLE: ready=1.
  - Non-header words are dropped silently.
  - On a header with base+len <= PROGRAM_SIZE (compute at 17 bits): latch base, len and autostart; set wr_ptr=base and remaining=len.
    - If len=0, go to DONE.
    - Otherwise go to LOAD.
  - On a header with base+len > PROGRAM_SIZE: set error=1 and stay in IDLE.
- State LOAD: ready=1.
  - An accepted header word (attr[0]=1) aborts the current load and sets error=1. It is then processed exactly as in IDLE, in the same cycle.
  - On a payload word:
    - Write the low half at wr_ptr in the next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=data[15:0].
    - Decrement remaining.
    - If remaining was 1, go to DONE; the high half is discarded.
    - Otherwise go to WRITE_HI and hold data[31:16].
- State WRITE_HI: ready=0.
  - Write the high half at wr_ptr+1.
  - Decrement remaining.
  - Return to LOAD, or go to DONE if remaining reaches 0.
- Write latency: mem_we asserts the cycle after acceptance. Exactly one instruction is written per cycle, and addresses increase strictly from base.
- State DONE: ready=0, one cycle.
  - If autostart, pu_jump=1 and pu_jump_addr=base for that cycle.
  - Then return to IDLE.
- busy = (state != IDLE).
- error is cleared only by pu_rst.
- Boundary base+len == PROGRAM_SIZE is legal; the last address written is PROGRAM_SIZE-1.
- No address wrap ever occurs.

Optional Feature:
- Macro: PU_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last payload word, state CHECK (ready=1) accepts one trailer word.
  - data[15:0] must equal the XOR of all written instructions. On mismatch, error=1 and no jump.
  - A header arriving in CHECK is handled as a header arriving in LOAD (abort).
  - DONE follows CHECK; for len=0 the expected checksum is 0.
- Disabled: no CHECK state; DONE follows the last write directly.

Test Plan:
- Header base=10 len=3 autostart, then payload 0xBBBBAAAA and 0x0000CCCC -> writes 10:AAAA, 11:BBBB, 12:CCCC; pu_jump high one cycle with pu_jump_addr=10; error=0.
- Header base=198 len=3 -> error=1, no mem_we, busy stays 0; then header base=198 len=2 with one payload word -> writes 198 and 199.
- Header len=4 base=0, one payload word, then a new header base=50 len=1 without autostart plus one payload -> error=1; writes 0 and 1, then 50; no jump.
- Header len=0 base=7 autostart -> no writes, jump to 7 two cycles after the header.
- Hold pu_valid_in low for 5 cycles between payload words, and drive pu_rst for one cycle during WRITE_HI -> writes stall without corruption; after reset busy=0, error=0 and no jump.
- PU_LOADER_CHECKSUM_EN: base=0 len=2, payload 0x00F000FF, trailer 0x000F -> jump; same load with trailer 0x0001 -> error=1 and no jump.
